step_motor_phase_gen: RTL and testbench
=======================================

# step_motor_phase_gen

Multi-channel stepper-motor phase sequencer for the MSE board. Each channel turns a queued move command (step count, direction, step mode, step period) into the four coil lines AX/AY/BX/BY. Per-channel output inversion lets one build drive both the inverted H-bridge axes and the non-inverted syringe driver. It sits between the serial-host command registers and the port pins, and replaces phase generation by the host.

## Interface
- `CHANNELS`, default 4: number of independent motor channels.
- `PERIOD_W`, default 16: width of the step period, in clocks.
- `STEPS_W`, default 16: width of the step count.
- `POS_W`, default 24: width of each signed position counter.
- `INVERT_MASK`, default 4'b0111: bit c=1 inverts all four coil outputs of channel c.

Ports:
- `MSE_SCLK` in 1: sole clock; all logic on the rising edge.
- `MSE_RESETN` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: combinational; equals `!busy[cmd_ch] && !abort[cmd_ch]`.
- `cmd_ch` in $clog2(CHANNELS): target channel.
- `cmd_steps` in STEPS_W: number of steps to move.
- `cmd_dir` in 1: 1 = forward (index +1, position +1); 0 = reverse.
- `cmd_mode` in 2: 0 = full (two-phase-on), 1 = half, 2 = wave (one-phase-on), 3 = treated as full.
- `cmd_period` in PERIOD_W: clocks per step; 0 is treated as 1.
- `cmd_hold` in 1: keep coils energised after completion.
- `abort` in CHANNELS: per-channel immediate stop.
- `busy` out CHANNELS: channel is executing a command.
- `done` out CHANNELS: one-cycle pulse on normal completion.
- `position` out CHANNELS*POS_W: signed step position per channel, channel 0 in the LSBs.
- `AX`, `AY`, `BX`, `BY` out CHANNELS each: coil drive lines, after inversion.

## Operation
- Phase index `idx` (0..7) selects coil states. Half-step table, as (coil A, coil B):
  - 0:(+,0) 1:(+,+) 2:(0,+) 3:(-,+)
  - 4:(-,0) 5:(-,-) 6:(0,-) 7:(+,-)
- Coil encoding: + gives X=1/Y=0; - gives X=0/Y=1; 0 gives X=0/Y=0. A de-energised coil is 0/0.
- Final output is the table value XOR `INVERT_MASK[c]`.
- Per-channel state machine:
  - IDLE: accepting `cmd_valid && cmd_ready` for this channel latches the command.
    - Full mode with even `idx`: `idx` += 1 (mod 8).
    - Wave mode with odd `idx`: `idx` -= 1 (mod 8).
    - This alignment is not counted as a step; position is unchanged.
    - Coils energise at the aligned `idx`; go to RUN, or to SETTLE if steps = 0.
  - RUN: every P clocks, `idx` moves ±1 (half) or ±2 (full/wave) mod 8 and position moves ±1. After the Nth step, go to SETTLE.
  - SETTLE: hold the last phase for P clocks, then go to IDLE.
    - Pulse `done`.
    - De-energise unless `cmd_hold`.
- `abort[c]` in RUN or SETTLE: go to IDLE on the next edge with no `done` pulse, coils de-energised regardless of hold. Position keeps the steps already taken.
- `abort[c]` in IDLE de-energises held coils.
- Position wraps modulo 2^POS_W.
- `idx` persists across commands.
- Commands to other channels are accepted while a channel is busy.

## Timing
- Reset values:
  - `idx` = 0, position = 0, state IDLE, `busy` = 0, `done` = 0.
  - All coils de-energised, so every output of channel c equals `INVERT_MASK[c]`.
- Reset asserted mid-move returns the channel to reset values immediately (asynchronous).
- Accept at edge t0: from t0 onward, `busy` = 1 and coils show the aligned phase.
- Step k updates `idx` and position at edge t0 + k·P.
- SETTLE ends at edge t0 + (N+1)·P:
  - `busy` falls at that edge.
  - `done` is high for exactly that one cycle.
  - Coils release (if not held) at that edge.
- `cmd_steps` = 0 gives `busy` for P cycles, then `done`.
- All outputs except `cmd_ready` are registered.

## Structure
- Package `step_motor_pkg` holds:
  - the mode enum;
  - the state enum {IDLE, RUN, SETTLE};
  - the 8-entry phase table as a constant;
  - the function mapping `idx` and energise to {AX, AY, BX, BY}.
- Sub-module `step_motor_channel` (one per channel, via generate) holds the state machine, period counter, step counter, `idx`, position and output inversion.
- The top level does only command demux, `cmd_ready` and output packing.

## Test plan
- Reset with defaults: channels 0–2 output AX/AY/BX/BY = 1111 and channel 3 = 0000; all positions 0; `busy` = 0.
- Channel 3, half mode, dir=1, steps=4, period=10, hold=0, accepted at t0:
  - AX/AY/BX/BY = 1000 from t0;
  - `idx` reaches 1, 2, 3, 4 at t0+10/20/30/40;
  - position = 4;
  - `done` pulses at t0+50, then outputs return to 0000.
- Channel 0, full mode from `idx` 0, dir=0, steps=3, period=1: aligned `idx` = 1, then 7, 5, 3; position = −3; outputs are the inverted table values.
- Abort channel 1 at the cycle of its 2nd step out of 10: `busy` falls next edge, no `done`, position = 2, outputs de-energised (1111) even with hold = 1.
- While channel 2 is busy, `cmd_ready` = 0 for `cmd_ch` = 2 and = 1 for `cmd_ch` = 0. Same-cycle `abort[0]` with a command to channel 0 gives `cmd_ready` = 0, and the command is not accepted.
- Run forward until position crosses 2^(POS_W−1) − 1: it wraps to −2^(POS_W−1). Period 0 behaves identically to period 1.

Source files
------------

// File: rtl/step_motor_pkg.sv
// step_motor_pkg: shared types, phase table and coil mapping for the stepper phase sequencer
package step_motor_pkg;
  typedef enum logic [1:0] {MODE_FULL = 2'd0, MODE_HALF = 2'd1, MODE_WAVE = 2'd2, MODE_FULL_ALT = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SETTLE = 2'd2} state_e;
  // {AX, AY, BX, BY} per half-step index, entry 0 in the LSBs
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0101, 4'b0100, 4'b0110, 4'b0010, 4'b1010, 4'b1000
  };
  function automatic logic [3:0] coil_drive(input logic [2:0] idx, input logic energise);
    return energise ? PHASE_TABLE[idx] : 4'b0000;
  endfunction
endpackage

// File: rtl/step_motor_channel.sv
// step_motor_channel: one motor's move state machine, step timing, position and coil drive
module step_motor_channel
  import step_motor_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W = 16,
  parameter int POS_W = 24,
  parameter logic INVERT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STEPS_W-1:0]  steps,
  input  logic                dir,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic                hold,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [POS_W-1:0]    position,
  output logic [3:0]          coils
);
  state_e state, n_state;
  mode_e m;
  logic [2:0] idx, n_idx, aligned, stride;
  logic [PERIOD_W-1:0] cnt, n_cnt, per_r, per_in;
  logic [STEPS_W-1:0] left, n_left;
  logic [POS_W-1:0] n_pos;
  logic energ, n_energ, n_done, dir_r, half_r, hold_r;
  assign m = mode_e'(mode);
  assign per_in = (period == '0) ? PERIOD_W'(1) : period;
  // full mode sits on odd (two-coil) indices, wave on even (one-coil) indices
  assign aligned = ((m == MODE_FULL || m == MODE_FULL_ALT) && !idx[0]) ? idx + 3'd1 :
                   (m == MODE_WAVE && idx[0]) ? idx - 3'd1 : idx;
  assign stride = half_r ? 3'd1 : 3'd2;
  always_comb begin
    n_state = state;
    n_idx = idx;
    n_pos = position;
    n_cnt = cnt;
    n_left = left;
    n_energ = energ;
    n_done = 1'b0;
    if (abort) begin
      n_state = IDLE;
      n_energ = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        n_state = (steps == '0) ? SETTLE : RUN;
        n_idx = aligned;
        n_energ = 1'b1;
        n_cnt = per_in - PERIOD_W'(1);
        n_left = steps;
      end
    end else if (cnt != '0) begin
      n_cnt = cnt - PERIOD_W'(1);
    end else if (state == RUN) begin
      n_state = (left == STEPS_W'(1)) ? SETTLE : RUN;
      n_idx = dir_r ? idx + stride : idx - stride;
      n_pos = dir_r ? position + POS_W'(1) : position - POS_W'(1);
      n_left = left - STEPS_W'(1);
      n_cnt = per_r - PERIOD_W'(1);
    end else begin
      n_state = IDLE;
      n_done = 1'b1;
      n_energ = hold_r;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      position <= '0;
      cnt <= '0;
      left <= '0;
      energ <= 1'b0;
      dir_r <= 1'b0;
      half_r <= 1'b0;
      per_r <= PERIOD_W'(1);
      hold_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      coils <= {4{INVERT}};
    end else begin
      state <= n_state;
      idx <= n_idx;
      position <= n_pos;
      cnt <= n_cnt;
      left <= n_left;
      energ <= n_energ;
      busy <= n_state != IDLE;
      done <= n_done;
      coils <= coil_drive(n_idx, n_energ) ^ {4{INVERT}};
      if (state == IDLE && start && !abort) begin
        dir_r <= dir;
        half_r <= m == MODE_HALF;
        per_r <= per_in;
        hold_r <= hold;
      end
    end
  end
endmodule

// File: rtl/step_motor_phase_gen.sv
// step_motor_phase_gen: multi-channel stepper phase sequencer; command demux and pin packing
module step_motor_phase_gen
  import step_motor_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 16,
  parameter int STEPS_W = 16,
  parameter int POS_W = 24,
  parameter logic [CHANNELS-1:0] INVERT_MASK = 4'b0111,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      MSE_SCLK,
  input  logic                      MSE_RESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [STEPS_W-1:0]        cmd_steps,
  input  logic                      cmd_dir,
  input  logic [1:0]                cmd_mode,
  input  logic [PERIOD_W-1:0]       cmd_period,
  input  logic                      cmd_hold,
  input  logic [CHANNELS-1:0]       abort,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*POS_W-1:0] position,
  output logic [CHANNELS-1:0]       AX,
  output logic [CHANNELS-1:0]       AY,
  output logic [CHANNELS-1:0]       BX,
  output logic [CHANNELS-1:0]       BY
);
  logic [3:0] coils [CHANNELS];
  assign cmd_ready = !busy[cmd_ch] && !abort[cmd_ch];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    step_motor_channel #(
      .PERIOD_W(PERIOD_W), .STEPS_W(STEPS_W), .POS_W(POS_W), .INVERT(INVERT_MASK[c])
    ) u_ch (
      .clk(MSE_SCLK),
      .rst_n(MSE_RESETN),
      .start(cmd_valid && cmd_ready && cmd_ch == CH_W'(c)),
      .steps(cmd_steps),
      .dir(cmd_dir),
      .mode(cmd_mode),
      .period(cmd_period),
      .hold(cmd_hold),
      .abort(abort[c]),
      .busy(busy[c]),
      .done(done[c]),
      .position(position[c*POS_W +: POS_W]),
      .coils(coils[c])
    );
    assign {AX[c], AY[c], BX[c], BY[c]} = coils[c];
  end
endmodule

// File: tb/tb_step_motor_phase_gen.sv
// tb_step_motor_phase_gen: randomized scenario bench against a table-driven motor model
module tb_step_motor_phase_gen;
  localparam int POS_W = 10;
  localparam logic [3:0] MASK = 4'b0111;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_hold = 1'b0, cmd_ready;
  logic [1:0] cmd_ch = '0, cmd_mode = '0;
  logic [15:0] cmd_steps = '0, cmd_period = '0;
  logic [3:0] abort = '0, busy, done, ax, ay, bx, by;
  logic [4*POS_W-1:0] position;
  int errors = 0, checks = 0;
  int m_idx [4], m_pos [4];
  int sa [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int sb [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  always #5 clk = ~clk;

  step_motor_phase_gen #(.POS_W(POS_W)) dut (
    .MSE_SCLK(clk), .MSE_RESETN(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
    .cmd_period(cmd_period), .cmd_hold(cmd_hold), .abort(abort), .busy(busy), .done(done),
    .position(position), .AX(ax), .AY(ay), .BX(bx), .BY(by)
  );

  function automatic logic [3:0] exp_coils(int i, bit en, int ch);
    logic [3:0] v;
    v = en ? {sa[i] > 0, sa[i] < 0, sb[i] > 0, sb[i] < 0} : 4'b0000;
    return v ^ {4{MASK[ch]}};
  endfunction
  function automatic logic [3:0] coils_of(int ch);
    return {ax[ch], ay[ch], bx[ch], by[ch]};
  endfunction
  function automatic logic [POS_W-1:0] pos_of(int ch);
    return position[ch*POS_W +: POS_W];
  endfunction
  function automatic logic [POS_W-1:0] wrap(int v);
    logic [31:0] t;
    t = v;
    return t[POS_W-1:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    for (int c = 0; c < 4; c++) begin
      m_idx[c] = 0;
      m_pos[c] = 0;
      checks++;
      if (coils_of(c) !== {4{MASK[c]}}) begin
        errors++; $display("FAIL reset_coils ch%0d: got %b want %b", c, coils_of(c), {4{MASK[c]}});
      end
      checks++;
      if (pos_of(c) !== '0) begin
        errors++; $display("FAIL reset_pos ch%0d: got %0d want 0", c, pos_of(c));
      end
    end
    checks++;
    if (busy !== 4'b0 || done !== 4'b0) begin
      errors++; $display("FAIL reset_busy_done: got %b/%b want 0000/0000", busy, done);
    end
  endtask

  task automatic run_move(int ch, int steps, bit dir, int mode, int period, bit hold);
    int p, a, d, sgn, end_t, k, ii;
    p = (period == 0) ? 1 : period;
    a = m_idx[ch];
    if ((mode == 0 || mode == 3) && a % 2 == 0) a = (a + 1) % 8;
    else if (mode == 2 && a % 2 == 1) a = (a + 7) % 8;
    d = (mode == 1) ? 1 : 2;
    sgn = dir ? 1 : -1;
    end_t = (steps + 1) * p;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_steps = 16'(steps); cmd_dir = dir;
    cmd_mode = 2'(mode); cmd_period = 16'(period); cmd_hold = hold;
    #1 checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL move_ready ch%0d: got %b want 1", ch, cmd_ready);
    end
    @(posedge clk) #1 cmd_valid = 1'b0;
    for (int j = 0; j <= end_t; j++) begin
      if (j > 0) @(posedge clk) #1;
      k = (j / p > steps) ? steps : j / p;
      ii = ((a + sgn * d * k) % 8 + 8) % 8;
      checks += 4;
      if (busy[ch] !== (j < end_t)) begin
        errors++; $display("FAIL move_busy ch%0d t0+%0d: got %b want %b", ch, j, busy[ch], j < end_t);
      end
      if (done[ch] !== (j == end_t)) begin
        errors++; $display("FAIL move_done ch%0d t0+%0d: got %b want %b", ch, j, done[ch], j == end_t);
      end
      if (pos_of(ch) !== wrap(m_pos[ch] + sgn * k)) begin
        errors++; $display("FAIL move_pos ch%0d t0+%0d: got %0d want %0d", ch, j, pos_of(ch), wrap(m_pos[ch] + sgn * k));
      end
      if (coils_of(ch) !== exp_coils(ii, (j < end_t) || hold, ch)) begin
        errors++; $display("FAIL move_coils ch%0d t0+%0d: got %b want %b", ch, j, coils_of(ch), exp_coils(ii, (j < end_t) || hold, ch));
      end
    end
    m_idx[ch] = ((a + sgn * d * steps) % 8 + 8) % 8;
    m_pos[ch] += sgn * steps;
  endtask

  task automatic test_abort();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_steps = 16'd10; cmd_dir = 1'b1;
    cmd_mode = 2'd1; cmd_period = 16'd4; cmd_hold = 1'b1;
    @(posedge clk) #1 cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 abort[1] = 1'b1;
    #1 checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready: got %b want 0", cmd_ready);
    end
    @(posedge clk) #1 abort[1] = 1'b0;
    m_idx[1] = (m_idx[1] + 2) % 8;
    m_pos[1] += 2;
    checks += 3;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      errors++; $display("FAIL abort_busy_done: got %b/%b want 0/0", busy[1], done[1]);
    end
    if (pos_of(1) !== wrap(m_pos[1])) begin
      errors++; $display("FAIL abort_pos: got %0d want %0d", pos_of(1), m_pos[1]);
    end
    if (coils_of(1) !== exp_coils(m_idx[1], 1'b0, 1)) begin
      errors++; $display("FAIL abort_coils: got %b want %b", coils_of(1), exp_coils(m_idx[1], 1'b0, 1));
    end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL abort_late: got done=%b busy=%b want 0/0", done[1], busy[1]);
    end
  endtask

  task automatic test_ready();
    int j;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_steps = 16'd5; cmd_dir = 1'b1;
    cmd_mode = 2'd0; cmd_period = 16'd3; cmd_hold = 1'b0;
    @(posedge clk) #1 cmd_valid = 1'b0;
    #1 checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_busy_ch2: got %b want 0", cmd_ready);
    end
    cmd_ch = 2'd0;
    #1 checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_idle_ch0: got %b want 1", cmd_ready);
    end
    abort[0] = 1'b1; cmd_valid = 1'b1; cmd_steps = 16'd3;
    #1 checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_abort_ch0: got %b want 0", cmd_ready);
    end
    @(posedge clk) #1;
    abort[0] = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || coils_of(0) !== exp_coils(m_idx[0], 1'b0, 0)) begin
      errors++; $display("FAIL ready_abort_accept: got busy=%b coils=%b want 0/%b", busy[0], coils_of(0), exp_coils(m_idx[0], 1'b0, 0));
    end
    j = 1;
    while (j < 60 && done[2] !== 1'b1) begin
      @(posedge clk) #1;
      j++;
    end
    m_idx[2] = (m_idx[2] + 1 + 2 * 5) % 8;
    m_pos[2] += 5;
    checks += 3;
    if (j != 18) begin
      errors++; $display("FAIL ready_ch2_done_time: got t0+%0d want t0+18", j);
    end
    if (busy[2] !== 1'b0 || pos_of(2) !== wrap(m_pos[2])) begin
      errors++; $display("FAIL ready_ch2_end: got busy=%b pos=%0d want 0/%0d", busy[2], pos_of(2), m_pos[2]);
    end
    if (coils_of(2) !== exp_coils(m_idx[2], 1'b0, 2)) begin
      errors++; $display("FAIL ready_ch2_coils: got %b want %b", coils_of(2), exp_coils(m_idx[2], 1'b0, 2));
    end
  endtask

  task automatic test_wrap();
    int got, want;
    run_move(1, (1 << (POS_W - 1)) - 1 - m_pos[1], 1'b1, 1, 0, 1'b0);
    run_move(1, 1, 1'b1, 1, 1, 1'b0);
    got = $signed(pos_of(1));
    want = -(1 << (POS_W - 1));
    checks++;
    if (got != want) begin
      errors++; $display("FAIL wrap_signed: got %0d want %0d", got, want);
    end
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 16; i++)
      run_move($urandom_range(0, 3), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_steps = 16'd20; cmd_dir = 1'b1;
    cmd_mode = 2'd1; cmd_period = 16'd2; cmd_hold = 1'b1;
    @(posedge clk) #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checks += 2;
    if (busy !== 4'b0 || position !== '0) begin
      errors++; $display("FAIL async_reset_state: got busy=%b pos=%0h want 0/0", busy, position);
    end
    if ({ax, ay, bx, by} !== {4{MASK}}) begin
      errors++; $display("FAIL async_reset_coils: got %b want %b", {ax, ay, bx, by}, {4{MASK}});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    run_move(3, 4, 1'b1, 1, 10, 1'b0);
    run_move(0, 3, 1'b0, 0, 1, 1'b0);
    test_abort();
    test_ready();
    test_wrap();
    test_random_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
